param_seq_detector: RTL and testbench
=====================================

# param_seq_detector

Parametrised Moore-style serial sequence detector: the next generation of the fixed 4-bit `1101` detector. It samples a qualified serial bit stream and matches it against a PAT_WIDTH-bit pattern that can be reloaded at run time. Overlapping or non-overlapping detection is selected at run time. A registered one-cycle `o` pulse flags each match. It sits on the serial input path beside the shift-register blocks, and an optional saturating match counter feeds status logic.

## Interface
- PAT_WIDTH, 4: pattern length in bits, legal range 2..16.
- PATTERN, 4'b1101: reset-value pattern, PAT_WIDTH bits; the MSB is the first bit received.
- CNT_WIDTH, 8: match counter width, legal range 1..16.
- clk  input  1  system clock; all state updates on the rising edge.
- n_rst  input  1  reset, synchronous and active-low; takes effect on the rising edge of clk while low.
- i  input  1  serial data bit.
- i_valid  input  1  sample `i` on this edge when high; hold all history when low.
- overlap  input  1  1 = overlapping detection, 0 = non-overlapping.
- pat_load  input  1  load `pat_in` as the active pattern.
- pat_in  input  PAT_WIDTH  new pattern value.
- clr_count  input  1  synchronous clear of `match_count`.
- o  output  1  registered match pulse.
- match_count  output  CNT_WIDTH  saturating count of matches.

## Operation
- State:
  - `hist`, a PAT_WIDTH-bit shift register; a new bit enters the LSB.
  - `fill`, a fill counter from 0 to PAT_WIDTH.
  - `pat`, the active pattern register.
- The FSM state is `fill`: EMPTY (0), FILLING (1..PAT_WIDTH-1), ARMED (PAT_WIDTH).
- Accepted bit (i_valid=1, pat_load=0):
  - `hist <= {hist[PAT_WIDTH-2:0], i}`.
  - `fill` increments, saturating at PAT_WIDTH.
- Match: the accepted bit leaves `fill == PAT_WIDTH` and the new `hist == pat`.
- On match with overlap=1: `hist` and `fill` are retained, so a suffix/prefix overlap can produce the next match.
- On match with overlap=0: `fill <= 0` and `hist <= 0`, so the next match needs PAT_WIDTH fresh bits.
- `overlap` is sampled only on the edge of a match. Changing it at other times has no effect.
- pat_load=1:
  - `pat <= pat_in`, `hist <= 0`, `fill <= 0`, `o <= 0`.
  - Any simultaneous `i` is discarded, because load has priority.
- Counter: `match_count` increments on each match and saturates at all-ones.
  - clr_count=1 forces 0 and has priority over a simultaneous match.
  - `o` still pulses when a match coincides with clr_count.
- Reset (n_rst=0 at the edge) sets:
  - `o=0` and `match_count=0`.
  - `hist=0` and `fill=0`.
  - `pat=PATTERN`.
- Reset overrides all other inputs. Reset mid-stream discards partial history.

## Timing
- `o` is driven only from a flop, with no combinational path from `i`.
- `o` is high for exactly the one cycle following the edge on which the matching bit was accepted.
- `o` is 0 on every other cycle, including cycles where i_valid=0.
- Minimum detection latency from the first bit after reset or load: PAT_WIDTH accepted bits, then one clock to `o`.
- Maximum `o` rate:
  - overlap=1: one pulse per accepted bit (e.g. pattern all-ones on an all-ones stream).
  - overlap=0: one pulse per PAT_WIDTH accepted bits.
- `match_count` updates on the same edge that sets `o`.
- Inputs are driven away from the rising edge; the bench drives them on the falling edge.

## Configuration
- Macro: `PARAM_SEQ_DETECTOR_COUNT_EN`.
- Defined: the match counter is built as described.
- Undefined:
  - No counter flops are built.
  - `match_count` is tied to 0 and `clr_count` is ignored.
  - The port list is unchanged.

## Structure
- Package `seq_det_pkg` holds:
  - the `fill_state_e` state-name constants (EMPTY/FILLING/ARMED) for waveform readability;
  - the PAT_WIDTH and CNT_WIDTH legal-range bounds;
  - the default pattern constant `SEQ_DET_DEF_PATTERN = 4'b1101`.
- Sub-module `sat_counter` (parameter WIDTH; ports clk, n_rst, inc, clr, count) implements the saturating counter.
  - It is instantiated only under `PARAM_SEQ_DETECTOR_COUNT_EN`.
- Elaboration checks reject out-of-range PAT_WIDTH and CNT_WIDTH.

## Test plan
- Reset: n_rst=0 for 2 cycles with i=1 and i_valid=1 -> o=0 and match_count=0 during and after reset release.
- Single match (default pattern, overlap=0): accept 1,1,0,1,0 -> o=1 for exactly one cycle after the 4th bit; match_count=1.
- Overlap: accept 1,1,0,1,1,0,1.
  - With overlap=1 -> two pulses, after bits 4 and 7; match_count=2.
  - With overlap=0 -> one pulse, after bit 4; match_count=1.
- No false match: 8 ones, then 8 zeros -> o=0 throughout.
- Gaps and mid-stream reset:
  - Accept 1,1,0 with an i_valid=0 gap between bits, then 1 -> one pulse.
  - Accept 1,1,0, apply reset, accept 1 -> no pulse.
- Pattern load and counter:
  - pat_load with pat_in=4'b0110, then accept 0,1,1,0 -> one pulse.
  - With CNT_WIDTH=2 and pattern 4'b1111, overlap=1, 8 ones -> 5 pulses; match_count saturates at 3.
  - clr_count on the 8th bit's edge -> match_count=0 while o still pulses.

Source files
------------

// File: rtl/seq_det_pkg.sv
// Shared definitions for param_seq_detector.
//   fill_state_e        : names for the fill-counter phases (EMPTY / FILLING / ARMED)
//   *_MIN / *_MAX       : legal ranges for PAT_WIDTH and CNT_WIDTH
//   SEQ_DET_DEF_PATTERN : default 4-bit pattern (1101, MSB received first)
//   fill_state_of()     : maps a fill count onto its fill_state_e phase
package seq_det_pkg;

  typedef enum logic [1:0] {
    StEmpty,
    StFilling,
    StArmed
  } fill_state_e;

  localparam int unsigned PAT_WIDTH_MIN = 2;
  localparam int unsigned PAT_WIDTH_MAX = 16;
  localparam int unsigned CNT_WIDTH_MIN = 1;
  localparam int unsigned CNT_WIDTH_MAX = 16;

  localparam logic [3:0] SEQ_DET_DEF_PATTERN = 4'b1101;

  function automatic fill_state_e fill_state_of(input int unsigned fill, input int unsigned width);
    if (fill == 0) return StEmpty;
    if (fill >= width) return StArmed;
    return StFilling;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
//   clk   : clock, rising edge
//   n_rst : synchronous active-low reset, clears the count
//   inc   : increment request; ignored once the count is all-ones
//   clr   : synchronous clear, wins over inc
//   count : current count value
module sat_counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != '1)) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/param_seq_detector.sv
// Parametrised Moore serial sequence detector with a run-time loadable pattern.
// Optional feature macro: PARAM_SEQ_DETECTOR_COUNT_EN builds the saturating match counter;
// without it match_count is tied to 0 and clr_count is ignored.
//   clk         : clock, rising edge
//   n_rst       : synchronous active-low reset
//   i / i_valid : serial bit and its qualifier
//   overlap     : 1 = keep history after a match, 0 = restart from empty
//   pat_load    : load pat_in as the active pattern (clears history, discards i)
//   pat_in      : new pattern, MSB is the first bit received
//   clr_count   : synchronous clear of match_count
//   o           : registered one-cycle match pulse
//   match_count : saturating match count
module param_seq_detector
  import seq_det_pkg::*;
#(
  parameter int unsigned          PAT_WIDTH = 4,
  parameter logic [PAT_WIDTH-1:0] PATTERN   = PAT_WIDTH'(SEQ_DET_DEF_PATTERN),
  parameter int unsigned          CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 i,
  input  logic                 i_valid,
  input  logic                 overlap,
  input  logic                 pat_load,
  input  logic [PAT_WIDTH-1:0] pat_in,
  input  logic                 clr_count,
  output logic                 o,
  output logic [CNT_WIDTH-1:0] match_count
);

  if (PAT_WIDTH < PAT_WIDTH_MIN || PAT_WIDTH > PAT_WIDTH_MAX) begin : gen_pat_width_check
    $error("param_seq_detector: PAT_WIDTH out of range");
  end
  if (CNT_WIDTH < CNT_WIDTH_MIN || CNT_WIDTH > CNT_WIDTH_MAX) begin : gen_cnt_width_check
    $error("param_seq_detector: CNT_WIDTH out of range");
  end

  localparam int unsigned      FillW    = $clog2(PAT_WIDTH + 1);
  localparam logic [FillW-1:0] FillFull = FillW'(PAT_WIDTH);

  logic [PAT_WIDTH-1:0] hist_q, hist_d, pat_q, pat_d, hist_shift;
  logic [FillW-1:0]     fill_q, fill_d, fill_inc;
  fill_state_e          state;
  logic                 match, o_q;

  always_comb state = fill_state_of(32'(fill_q), PAT_WIDTH);

  // State register.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      hist_q <= '0;
      fill_q <= '0;
      pat_q  <= PATTERN;
      o_q    <= 1'b0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
      pat_q  <= pat_d;
      o_q    <= match;
    end
  end

  // Next state; pat_load outranks an accepted bit.
  always_comb begin
    hist_d     = hist_q;
    fill_d     = fill_q;
    pat_d      = pat_q;
    match      = 1'b0;
    hist_shift = {hist_q[PAT_WIDTH-2:0], i};
    fill_inc   = (state == StArmed) ? fill_q : fill_q + FillW'(1);
    if (pat_load) begin
      pat_d  = pat_in;
      hist_d = '0;
      fill_d = '0;
    end else if (i_valid) begin
      match = (fill_inc == FillFull) && (hist_shift == pat_q);
      if (match && !overlap) begin
        hist_d = '0;
        fill_d = '0;
      end else begin
        hist_d = hist_shift;
        fill_d = fill_inc;
      end
    end
  end

  // Outputs come straight from flops.
  always_comb o = o_q;

`ifdef PARAM_SEQ_DETECTOR_COUNT_EN
  sat_counter #(
    .WIDTH(CNT_WIDTH)
  ) u_sat_counter (
    .clk  (clk),
    .n_rst(n_rst),
    .inc  (match),
    .clr  (clr_count),
    .count(match_count)
  );
`else
  logic unused_clr_count;
  assign unused_clr_count = clr_count;
  assign match_count      = '0;
`endif

endmodule

// File: tb/tb_param_seq_detector.sv
// Directed, table-driven bench for param_seq_detector (PAT_WIDTH=4, CNT_WIDTH=2).
module tb_param_seq_detector;

`ifdef PARAM_SEQ_DETECTOR_COUNT_EN
  localparam bit CountEn = 1'b1;
`else
  localparam bit CountEn = 1'b0;
`endif

  logic       tb_clk = 1'b0;
  logic       n_rst, i, i_valid, overlap, pat_load, clr_count;
  logic [3:0] pat_in;
  logic       o;
  logic [1:0] match_count;

  int checks = 0;
  int errors = 0;

  always #5 tb_clk = ~tb_clk;

  param_seq_detector #(
    .PAT_WIDTH(4),
    .PATTERN  (4'b1101),
    .CNT_WIDTH(2)
  ) u_dut (
    .clk        (tb_clk),
    .n_rst      (n_rst),
    .i          (i),
    .i_valid    (i_valid),
    .overlap    (overlap),
    .pat_load   (pat_load),
    .pat_in     (pat_in),
    .clr_count  (clr_count),
    .o          (o),
    .match_count(match_count)
  );

  typedef struct {
    logic       n_rst;
    logic       i;
    logic       i_valid;
    logic       overlap;
    logic       pat_load;
    logic [3:0] pat_in;
    logic       clr;
    logic       exp_o;
    logic [1:0] exp_cnt;
    string      name;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [1:0] ec(input logic [1:0] c);
    return CountEn ? c : 2'd0;
  endfunction

  function automatic void add(input logic r, input logic ii, input logic iv, input logic ov,
                              input logic ld, input logic [3:0] pin, input logic clr,
                              input logic eo, input logic [1:0] cnt, input string nm);
    vec_t v;
    v.n_rst = r; v.i = ii; v.i_valid = iv; v.overlap = ov; v.pat_load = ld;
    v.pat_in = pin; v.clr = clr; v.exp_o = eo; v.exp_cnt = ec(cnt); v.name = nm;
    vecs.push_back(v);
  endfunction

  function automatic void add_bit(input logic ii, input logic ov, input logic eo,
                                  input logic [1:0] cnt, input string nm);
    add(1'b1, ii, 1'b1, ov, 1'b0, 4'b0000, 1'b0, eo, cnt, nm);
  endfunction

  function automatic void add_idle(input logic [1:0] cnt, input string nm);
    add(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, cnt, nm);
  endfunction

  function automatic void add_rst(input string nm);
    add(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 2'd0, nm);
  endfunction

  task automatic apply(input vec_t v);
    @(negedge tb_clk);
    n_rst = v.n_rst; i = v.i; i_valid = v.i_valid; overlap = v.overlap;
    pat_load = v.pat_load; pat_in = v.pat_in; clr_count = v.clr;
    @(posedge tb_clk);
    #1;
    checks++;
    if (o !== v.exp_o) begin
      errors++;
      $display("FAIL %s: o got %b, expected %b", v.name, o, v.exp_o);
    end
    checks++;
    if (match_count !== v.exp_cnt) begin
      errors++;
      $display("FAIL %s: match_count got %0d, expected %0d", v.name, match_count, v.exp_cnt);
    end
  endtask

  initial begin
    vec_t v;
    n_rst = 1'b0; i = 1'b0; i_valid = 1'b0; overlap = 1'b0;
    pat_load = 1'b0; pat_in = 4'b0000; clr_count = 1'b0;

    // Reset held two cycles with live input, then released.
    add_rst("reset_c0");
    add_rst("reset_c1");
    add_idle(2'd0, "reset_release");

    // Single match, non-overlapping.
    add_bit(1'b1, 1'b0, 1'b0, 2'd0, "single_b1");
    add_bit(1'b1, 1'b0, 1'b0, 2'd0, "single_b2");
    add_bit(1'b0, 1'b0, 1'b0, 2'd0, "single_b3");
    add_bit(1'b1, 1'b0, 1'b1, 2'd1, "single_b4");
    add_bit(1'b0, 1'b0, 1'b0, 2'd1, "single_b5");
    add_idle(2'd1, "single_idle");

    // Overlapping: 1101101 -> pulses after bits 4 and 7.
    add_rst("ovl_rst");
    add_bit(1'b1, 1'b1, 1'b0, 2'd0, "ovl_b1");
    add_bit(1'b1, 1'b1, 1'b0, 2'd0, "ovl_b2");
    add_bit(1'b0, 1'b1, 1'b0, 2'd0, "ovl_b3");
    add_bit(1'b1, 1'b1, 1'b1, 2'd1, "ovl_b4");
    add_bit(1'b1, 1'b1, 1'b0, 2'd1, "ovl_b5");
    add_bit(1'b0, 1'b1, 1'b0, 2'd1, "ovl_b6");
    add_bit(1'b1, 1'b1, 1'b1, 2'd2, "ovl_b7");
    add_idle(2'd2, "ovl_idle");

    // Same stream, non-overlapping -> only the first pulse.
    add_rst("novl_rst");
    add_bit(1'b1, 1'b0, 1'b0, 2'd0, "novl_b1");
    add_bit(1'b1, 1'b0, 1'b0, 2'd0, "novl_b2");
    add_bit(1'b0, 1'b0, 1'b0, 2'd0, "novl_b3");
    add_bit(1'b1, 1'b0, 1'b1, 2'd1, "novl_b4");
    add_bit(1'b1, 1'b0, 1'b0, 2'd1, "novl_b5");
    add_bit(1'b0, 1'b0, 1'b0, 2'd1, "novl_b6");
    add_bit(1'b1, 1'b0, 1'b0, 2'd1, "novl_b7");

    // No false match on runs of ones then zeros.
    add_rst("runs_rst");
    for (int k = 0; k < 8; k++) add_bit(1'b1, 1'b1, 1'b0, 2'd0, "runs_one");
    for (int k = 0; k < 8; k++) add_bit(1'b0, 1'b1, 1'b0, 2'd0, "runs_zero");

    // Gaps hold history; pulse stays one cycle into an idle cycle.
    add_rst("gap_rst");
    add_bit(1'b1, 1'b0, 1'b0, 2'd0, "gap_b1");
    add_idle(2'd0, "gap_g1");
    add_bit(1'b1, 1'b0, 1'b0, 2'd0, "gap_b2");
    add_idle(2'd0, "gap_g2");
    add_bit(1'b0, 1'b0, 1'b0, 2'd0, "gap_b3");
    add_idle(2'd0, "gap_g3");
    add_bit(1'b1, 1'b0, 1'b1, 2'd1, "gap_b4");
    add_idle(2'd1, "gap_after");

    // Reset mid-stream discards partial history.
    add_rst("mid_rst0");
    add_bit(1'b1, 1'b0, 1'b0, 2'd0, "mid_b1");
    add_bit(1'b1, 1'b0, 1'b0, 2'd0, "mid_b2");
    add_bit(1'b0, 1'b0, 1'b0, 2'd0, "mid_b3");
    add_rst("mid_rst1");
    add_bit(1'b1, 1'b0, 1'b0, 2'd0, "mid_b4");

    // Pattern load: bit on the load edge is dropped, so 1,1,0 leaves fill at 3.
    add(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 4'b0110, 1'b0, 1'b0, 2'd0, "load1");
    add_bit(1'b1, 1'b0, 1'b0, 2'd0, "load1_b1");
    add_bit(1'b1, 1'b0, 1'b0, 2'd0, "load1_b2");
    add_bit(1'b0, 1'b0, 1'b0, 2'd0, "load1_b3");
    add(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 4'b0110, 1'b0, 1'b0, 2'd0, "load2");
    add_bit(1'b0, 1'b0, 1'b0, 2'd0, "load2_b1");
    add_bit(1'b1, 1'b0, 1'b0, 2'd0, "load2_b2");
    add_bit(1'b1, 1'b0, 1'b0, 2'd0, "load2_b3");
    add_bit(1'b0, 1'b0, 1'b1, 2'd1, "load2_b4");

    foreach (vecs[k]) apply(vecs[k]);

    // Saturation: pattern 1111, overlap, 8 ones; clr_count on the 8th bit.
    v = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 2'd0, "sat_rst"};
    apply(v);
    v = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 4'b1111, 1'b0, 1'b0, 2'd0, "sat_load"};
    apply(v);
    for (int k = 1; k <= 8; k++) begin
      logic [1:0] c;
      c = (k < 4) ? 2'd0 : ((k - 3 > 3) ? 2'd3 : 2'(k - 3));
      if (k == 8) c = 2'd0;
      v = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0000, (k == 8), (k >= 4), ec(c), $sformatf("sat_b%0d", k)};
      apply(v);
    end
    v = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 2'd0, "sat_idle"};
    apply(v);

    // Reset restores the default pattern 1101.
    v = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 2'd0, "def_rst"};
    apply(v);
    for (int k = 0; k < 4; k++) begin
      logic [3:0] bits;
      bits = 4'b1101;
      v = '{1'b1, bits[3-k], 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, (k == 3),
            ec((k == 3) ? 2'd1 : 2'd0), $sformatf("def_b%0d", k + 1)};
      apply(v);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
